// File: rtl/i2c_pkg.sv
// Shared I2C definitions: FSM state encoding, default target address, filter helper.
package i2c_pkg;

  localparam logic [6:0] I2C_DEFAULT_ADDR = 7'h42;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_ADDR,
    ST_ADDR_ACK,
    ST_PTR,
    ST_PTR_ACK,
    ST_WDATA,
    ST_WDATA_ACK,
    ST_RDATA,
    ST_RDATA_ACK,
    ST_IGNORE
  } i2c_state_t;

  function automatic logic majority3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

endpackage

// File: rtl/i2c_pin_filter.sv
// Two-flop synchroniser plus 3-sample majority filter for one open-drain pin.
// The filtered level changes 4 clk after the pin; rise/fall are valid the cycle after.
module i2c_pin_filter
  import i2c_pkg::*;
(
  input  logic clk,
  input  logic reset,
  input  logic pin,
  output logic level,
  output logic rise,
  output logic fall
);

  logic [1:0] sync_reg;
  logic [1:0] hist_reg;
  logic       level_reg;
  logic       level_d_reg;

  // Idle bus is high, so everything resets to 1 to avoid a false edge.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync_reg    <= 2'b11;
      hist_reg    <= 2'b11;
      level_reg   <= 1'b1;
      level_d_reg <= 1'b1;
    end else begin
      sync_reg    <= {sync_reg[0], pin};
      hist_reg    <= {hist_reg[0], sync_reg[1]};
      level_reg   <= majority3(hist_reg[1], hist_reg[0], sync_reg[1]);
      level_d_reg <= level_reg;
    end
  end

  assign level = level_reg;
  assign rise  = level_reg & ~level_d_reg;
  assign fall  = ~level_reg & level_d_reg;

endmodule

// File: rtl/i2c_target.sv
// I2C target exposing a small register file to an external controller, with a
// local host read/write port onto the same registers.
module i2c_target
  import i2c_pkg::*;
#(
  parameter logic [6:0] I2C_ADDR = I2C_DEFAULT_ADDR,
  parameter int          NUM_REGS = 16,
  localparam int         PW = $clog2(NUM_REGS)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          scl_i,
  input  logic          sda_i,
  output logic          sda_oe,
  input  logic [PW-1:0] host_addr,
  input  logic          host_we,
  input  logic [7:0]    host_wdata,
  output logic [7:0]    host_rdata,
  output logic          wr_valid,
  output logic [PW-1:0] wr_addr,
  output logic [7:0]    wr_data,
  output logic          busy
);

  logic scl_level, scl_rise, scl_fall;
  logic sda_level, sda_rise, sda_fall;

  i2c_pin_filter u_scl_filter (
    .clk(clk), .reset(reset), .pin(scl_i),
    .level(scl_level), .rise(scl_rise), .fall(scl_fall)
  );

  i2c_pin_filter u_sda_filter (
    .clk(clk), .reset(reset), .pin(sda_i),
    .level(sda_level), .rise(sda_rise), .fall(sda_fall)
  );

  logic       start_det, stop_det;
  assign start_det = sda_fall & scl_level;
  assign stop_det  = sda_rise & scl_level;

  i2c_state_t    state_reg, state_next;
  logic [2:0]    bit_cnt_reg, bit_cnt_next;
  logic [7:0]    shift_reg, shift_next;
  logic [PW-1:0] ptr_reg, ptr_next;
  logic          sda_oe_reg, sda_oe_next;
  logic          ack_on_reg, ack_on_next;
  logic          rw_reg, rw_next;
  logic          busy_reg, busy_next;
  logic          wr_valid_reg, wr_valid_next;
  logic [PW-1:0] wr_addr_reg, wr_addr_next;
  logic [7:0]    wr_data_reg, wr_data_next;
  logic          i2c_we;
  logic [7:0]    rx_byte;
  logic [7:0]    rd_byte;
  logic [7:0]    regs [NUM_REGS];

  assign rx_byte = {shift_reg[6:0], sda_level};
  assign rd_byte = regs[ptr_reg];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg    <= ST_IDLE;
      bit_cnt_reg  <= '0;
      shift_reg    <= '0;
      ptr_reg      <= '0;
      sda_oe_reg   <= 1'b0;
      ack_on_reg   <= 1'b0;
      rw_reg       <= 1'b0;
      busy_reg     <= 1'b0;
      wr_valid_reg <= 1'b0;
      wr_addr_reg  <= '0;
      wr_data_reg  <= '0;
    end else begin
      state_reg    <= state_next;
      bit_cnt_reg  <= bit_cnt_next;
      shift_reg    <= shift_next;
      ptr_reg      <= ptr_next;
      sda_oe_reg   <= sda_oe_next;
      ack_on_reg   <= ack_on_next;
      rw_reg       <= rw_next;
      busy_reg     <= busy_next;
      wr_valid_reg <= wr_valid_next;
      wr_addr_reg  <= wr_addr_next;
      wr_data_reg  <= wr_data_next;
    end
  end

  always_comb begin
    state_next    = state_reg;
    bit_cnt_next  = bit_cnt_reg;
    shift_next    = shift_reg;
    ptr_next      = ptr_reg;
    sda_oe_next   = sda_oe_reg;
    ack_on_next   = ack_on_reg;
    rw_next       = rw_reg;
    busy_next     = busy_reg;
    wr_valid_next = 1'b0;
    wr_addr_next  = wr_addr_reg;
    wr_data_next  = wr_data_reg;
    i2c_we        = 1'b0;

    if (stop_det) begin
      state_next  = ST_IDLE;
      sda_oe_next = 1'b0;
      ack_on_next = 1'b0;
      busy_next   = 1'b0;
    end else if (start_det) begin
      state_next   = ST_ADDR;
      bit_cnt_next = '0;
      sda_oe_next  = 1'b0;
      ack_on_next  = 1'b0;
    end else begin
      case (state_reg)
        ST_ADDR, ST_PTR, ST_WDATA: begin
          if (scl_rise) begin
            shift_next   = rx_byte;
            bit_cnt_next = bit_cnt_reg + 3'd1;
            if (bit_cnt_reg == 3'd7) begin
              case (state_reg)
                ST_ADDR: begin
                  if (rx_byte[7:1] == I2C_ADDR) begin
                    state_next = ST_ADDR_ACK;
                    rw_next    = rx_byte[0];
                    busy_next  = 1'b1;
                  end else begin
                    state_next = ST_IGNORE;
                    busy_next  = 1'b0;
                  end
                end
                ST_PTR: begin
                  ptr_next   = rx_byte[PW-1:0];
                  state_next = ST_PTR_ACK;
                end
                default: begin
                  i2c_we        = 1'b1;
                  wr_valid_next = 1'b1;
                  wr_addr_next  = ptr_reg;
                  wr_data_next  = rx_byte;
                  ptr_next      = ptr_reg + PW'(1);
                  state_next    = ST_WDATA_ACK;
                end
              endcase
            end
          end
        end

        // First fall after the byte pulls SDA low; the second ends the ACK slot.
        ST_ADDR_ACK, ST_PTR_ACK, ST_WDATA_ACK: begin
          if (scl_fall) begin
            if (!ack_on_reg) begin
              sda_oe_next = 1'b1;
              ack_on_next = 1'b1;
            end else begin
              ack_on_next  = 1'b0;
              sda_oe_next  = 1'b0;
              bit_cnt_next = '0;
              if (state_reg == ST_ADDR_ACK && rw_reg) begin
                shift_next  = {rd_byte[6:0], 1'b0};
                sda_oe_next = ~rd_byte[7];
                state_next  = ST_RDATA;
              end else if (state_reg == ST_ADDR_ACK) begin
                state_next = ST_PTR;
              end else begin
                state_next = ST_WDATA;
              end
            end
          end
        end

        // The MSB goes out on the fall that enters this state; shift holds the rest.
        ST_RDATA: begin
          if (scl_fall) begin
            sda_oe_next = ~shift_reg[7];
            shift_next  = {shift_reg[6:0], 1'b0};
          end
          if (scl_rise) begin
            bit_cnt_next = bit_cnt_reg + 3'd1;
            if (bit_cnt_reg == 3'd7) begin
              state_next  = ST_RDATA_ACK;
              ack_on_next = 1'b0;
            end
          end
        end

        ST_RDATA_ACK: begin
          if (scl_fall) begin
            if (!ack_on_reg) begin
              sda_oe_next = 1'b0;
            end else begin
              ack_on_next  = 1'b0;
              bit_cnt_next = '0;
              shift_next   = {rd_byte[6:0], 1'b0};
              sda_oe_next  = ~rd_byte[7];
              state_next   = ST_RDATA;
            end
          end
          if (scl_rise && !ack_on_reg) begin
            ptr_next = ptr_reg + PW'(1);
            if (sda_level) begin
              state_next = ST_IGNORE;
            end else begin
              ack_on_next = 1'b1;
            end
          end
        end

        default: ;
      endcase
    end
  end

  // I2C write has priority over a host write to the same index in the same cycle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
    end else begin
      for (int i = 0; i < NUM_REGS; i++) begin
        if (i2c_we && ptr_reg == PW'(i)) begin
          regs[i] <= rx_byte;
        end else if (host_we && host_addr == PW'(i)) begin
          regs[i] <= host_wdata;
        end
      end
    end
  end

  assign host_rdata = regs[host_addr];
  assign sda_oe     = sda_oe_reg;
  assign wr_valid   = wr_valid_reg;
  assign wr_addr    = wr_addr_reg;
  assign wr_data    = wr_data_reg;
  assign busy       = busy_reg;

endmodule

// File: tb/tb_i2c_target.sv
// Bench for i2c_target: bit-banged controller on a wired-AND SDA line, checked
// against a register-array model of the target's address space.
module tb_i2c_target;

  localparam int Q = 9;  // quarter of an SCL period in clk cycles (SCL = 36 clk)

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       scl = 1'b1;
  logic       sda_m = 1'b1;
  logic [3:0] host_addr = '0;
  logic       host_we = 1'b0;
  logic [7:0] host_wdata = '0;
  logic       sda_oe, busy, wr_valid;
  logic [3:0] wr_addr;
  logic [7:0] wr_data, host_rdata;
  logic       sda_line;

  assign sda_line = sda_m & ~sda_oe;

  always #5 clk = ~clk;

  i2c_target #(.I2C_ADDR(7'h42), .NUM_REGS(16)) dut (
    .clk(clk), .reset(reset), .scl_i(scl), .sda_i(sda_line), .sda_oe(sda_oe),
    .host_addr(host_addr), .host_we(host_we), .host_wdata(host_wdata),
    .host_rdata(host_rdata), .wr_valid(wr_valid), .wr_addr(wr_addr),
    .wr_data(wr_data), .busy(busy)
  );

  int         checks = 0;
  int         errors = 0;
  logic [7:0] model_regs [16];
  int         model_ptr = 0;
  logic [11:0] wr_q [$];
  logic [11:0] exp_q [$];
  int         oe_cycles = 0;
  int         busy_cycles = 0;

  always @(posedge clk) begin
    if (wr_valid) wr_q.push_back({wr_addr, wr_data});
    if (sda_oe) oe_cycles <= oe_cycles + 1;
    if (busy) busy_cycles <= busy_cycles + 1;
  end

  initial begin
    #1500000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // mode 0 plain, 1 glitch SDA mid-high, 2 host write in the I2C write cycle
  task automatic send_bit(input logic b, input int mode, output logic smp);
    sda_m = b;
    tick(Q);
    scl = 1'b1;
    if (mode == 1) begin
      tick(3); sda_m = ~b; tick(1); sda_m = b; tick(Q - 4);
    end else if (mode == 2) begin
      tick(4); host_we = 1'b1; tick(1); host_we = 1'b0;
      check("wr_valid_timing", wr_valid, 1);
      tick(Q - 5);
    end else begin
      tick(Q);
    end
    smp = sda_line;
    tick(Q);
    scl = 1'b0;
    tick(Q);
  endtask

  task automatic i2c_start();
    sda_m = 1'b1; tick(Q);
    scl = 1'b1;   tick(Q);
    sda_m = 1'b0; tick(Q);
    scl = 1'b0;   tick(Q);
  endtask

  task automatic i2c_stop();
    sda_m = 1'b0; tick(Q);
    scl = 1'b1;   tick(Q);
    sda_m = 1'b1; tick(Q);
  endtask

  task automatic write_byte(input logic [7:0] b, input int mode, output logic ack);
    logic s;
    for (int i = 7; i >= 0; i--) send_bit(b[i], (mode == 2 && i == 0) ? 2 : (mode == 1 ? 1 : 0), s);
    send_bit(1'b1, 0, s);
    ack = ~s;
  endtask

  task automatic read_byte(input logic ack, output logic [7:0] d);
    logic s;
    for (int i = 7; i >= 0; i--) begin
      send_bit(1'b1, 0, s);
      d[i] = s;
    end
    send_bit(~ack, 0, s);
  endtask

  task automatic host_write(input int a, input logic [7:0] d);
    host_addr = 4'(a); host_wdata = d; host_we = 1'b1;
    tick(1);
    host_we = 1'b0;
    model_regs[a] = d;
    check("host_rdata_after_we", host_rdata, d);
  endtask

  task automatic compare_regs();
    for (int i = 0; i < 16; i++) begin
      host_addr = 4'(i);
      #1;
      check($sformatf("regs[%0d]", i), host_rdata, model_regs[i]);
    end
  endtask

  task automatic compare_wr_events();
    check("wr_valid_count", wr_q.size(), exp_q.size());
    while (wr_q.size() > 0 && exp_q.size() > 0)
      check("wr_addr_data", wr_q.pop_front(), exp_q.pop_front());
    wr_q.delete();
    exp_q.delete();
  endtask

  task automatic i2c_write_txn(input int p, input logic [7:0] data [4], input int n, input int mode);
    logic ack;
    i2c_start();
    write_byte(8'h84, 0, ack);
    check("addr_w_ack", ack, 1);
    write_byte(8'(p), 0, ack);
    check("ptr_ack", ack, 1);
    check("busy_in_txn", busy, 1);
    for (int i = 0; i < n; i++) begin
      write_byte(data[i], mode, ack);
      check("data_ack", ack, 1);
      model_regs[(p + i) % 16] = data[i];
      exp_q.push_back({4'((p + i) % 16), data[i]});
    end
    check("busy_before_stop", busy, 1);
    i2c_stop();
    check("busy_after_stop", busy, 0);
    model_ptr = (p + n) % 16;
    compare_wr_events();
  endtask

  // set_ptr < 0 means a current-address read with no pointer write.
  task automatic i2c_read_txn(input int set_ptr, input int n);
    logic ack;
    logic [7:0] d;
    int p;
    i2c_start();
    if (set_ptr >= 0) begin
      write_byte(8'h84, 0, ack);
      check("addr_w_ack", ack, 1);
      write_byte(8'(set_ptr), 0, ack);
      check("ptr_ack", ack, 1);
      model_ptr = set_ptr;
      i2c_start();
    end
    write_byte(8'h85, 0, ack);
    check("addr_r_ack", ack, 1);
    p = model_ptr;
    for (int i = 0; i < n; i++) begin
      read_byte(i < n - 1, d);
      check("read_data", d, model_regs[(p + i) % 16]);
    end
    model_ptr = (p + n) % 16;
    check("sda_released_after_nack", sda_oe, 0);
    i2c_stop();
    compare_wr_events();
  endtask

  initial begin
    logic [7:0] buf4 [4];
    logic ack;
    int oe0, busy0;

    for (int i = 0; i < 16; i++) model_regs[i] = '0;

    // Reset values
    tick(5);
    check("rst_sda_oe", sda_oe, 0);
    check("rst_wr_valid", wr_valid, 0);
    check("rst_wr_addr", wr_addr, 0);
    check("rst_wr_data", wr_data, 0);
    check("rst_busy", busy, 0);
    check("rst_host_rdata", host_rdata, 0);
    reset = 1'b0;
    tick(10);

    // Write burst
    buf4 = '{8'hA5, 8'h5A, 8'h00, 8'h00};
    i2c_write_txn(3, buf4, 2, 0);
    compare_regs();

    // Repeated-START read of a host-written register
    host_write(7, 8'h3C);
    i2c_read_txn(7, 1);
    oe0 = oe_cycles;
    tick(50);
    check("sda_oe_stays_low", oe_cycles - oe0, 0);

    // Address mismatch
    oe0 = oe_cycles; busy0 = busy_cycles;
    i2c_start();
    write_byte(8'h86, 0, ack);
    check("mismatch_addr_nack", ack, 0);
    write_byte(8'h11, 0, ack);
    check("mismatch_data_nack", ack, 0);
    i2c_stop();
    check("mismatch_sda_oe_cycles", oe_cycles - oe0, 0);
    check("mismatch_busy_cycles", busy_cycles - busy0, 0);
    compare_wr_events();

    // Pointer wrap
    buf4 = '{8'h11, 8'h22, 8'h00, 8'h00};
    i2c_write_txn(15, buf4, 2, 0);
    check("wrap_ptr_model", model_ptr, 1);
    compare_regs();

    // Same-cycle host/I2C write collision on regs[2]
    host_addr = 4'd2; host_wdata = 8'hFF;
    buf4 = '{8'h01, 8'h00, 8'h00, 8'h00};
    i2c_write_txn(2, buf4, 1, 2);
    host_addr = 4'd2;
    #1;
    check("collision_regs2", host_rdata, 8'h01);

    // Glitches while SCL is high must not be taken as START/STOP
    buf4 = '{8'h96, 8'h00, 8'h00, 8'h00};
    i2c_write_txn(10, buf4, 1, 1);
    compare_regs();

    // Randomized mix of bursts, reads and host writes
    for (int t = 0; t < 10; t++) begin
      int op, p, n;
      op = int'($urandom_range(0, 3));
      p  = int'($urandom_range(0, 15));
      n  = int'($urandom_range(1, 3));
      if (op == 0) begin
        for (int i = 0; i < 4; i++) buf4[i] = 8'($urandom);
        i2c_write_txn(p, buf4, n, 0);
      end else if (op == 1) begin
        i2c_read_txn(p, n);
      end else if (op == 2) begin
        i2c_read_txn(-1, n);
      end else begin
        host_write(p, 8'($urandom));
      end
    end
    compare_regs();

    // Reset during a write ACK aborts the transfer and clears everything
    i2c_start();
    write_byte(8'h84, 0, ack);
    write_byte(8'h05, 0, ack);
    for (int i = 7; i >= 0; i--) begin
      logic s;
      send_bit(buf4[0][i], 0, s);
    end
    sda_m = 1'b1;
    tick(Q);
    check("abort_ack_driven", sda_oe, 1);
    reset = 1'b1;
    #1;
    check("abort_sda_oe_immediate", sda_oe, 0);
    tick(2);
    for (int i = 0; i < 16; i++) model_regs[i] = '0;
    model_ptr = 0;
    compare_regs();
    check("abort_busy", busy, 0);
    reset = 1'b0;
    wr_q.delete();
    exp_q.delete();
    tick(10);
    i2c_stop();
    buf4 = '{8'h44, 8'h00, 8'h00, 8'h00};
    i2c_write_txn(1, buf4, 1, 0);
    compare_regs();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
